// File: rtl/food_placer.sv
`default_nettype none
// ============================================================================
// food_placer : places food at a free grid cell, random draws then raster scan
// Rev 1.0
// ============================================================================
module food_placer #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int MAX_TRIES = 8,
  parameter int INIT_X    = 20,
  parameter int INIT_Y    = 12,
  localparam int XW = (GRID_W > 2) ? $clog2(GRID_W) : 1,
  localparam int YW = (GRID_H > 2) ? $clog2(GRID_H) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          place_req,
  input  logic [7:0]    rnd,
  output logic          q_valid,
  output logic [XW-1:0] q_x,
  output logic [YW-1:0] q_y,
  input  logic          occ_hit,
  output logic          busy,
  output logic [XW-1:0] food_x,
  output logic [YW-1:0] food_y,
  output logic          food_valid,
  output logic          grid_full
);

  localparam int              c_CW       = $clog2(GRID_W * GRID_H) + 1;
  localparam int              c_TW       = $clog2(MAX_TRIES + 1);
  localparam logic [XW:0]     c_GW_EXT   = (XW + 1)'(GRID_W);
  localparam logic [YW:0]     c_GH_EXT   = (YW + 1)'(GRID_H);
  localparam logic [XW-1:0]   c_GW_LO    = XW'(GRID_W);
  localparam logic [YW-1:0]   c_GH_LO    = YW'(GRID_H);
  localparam logic [XW-1:0]   c_X_LAST   = XW'(GRID_W - 1);
  localparam logic [YW-1:0]   c_Y_LAST   = YW'(GRID_H - 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(GRID_W * GRID_H - 1);
  localparam logic [c_TW-1:0] c_TRIES    = c_TW'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAW_X = 3'd1,
    S_DRAW_Y = 3'd2,
    S_QUERY  = 3'd3,
    S_CHECK  = 3'd4,
    S_SCAN   = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  state_t          r_state;
  logic [XW-1:0]   r_cand_x, r_q_x, r_food_x;
  logic [YW-1:0]   r_cand_y, r_q_y, r_food_y;
  logic [c_TW-1:0] r_tries;
  logic [c_CW-1:0] r_scan_cnt;
  logic            r_scan_mode, r_q_valid, r_busy, r_food_valid, r_grid_full;

  logic [XW-1:0]   w_rx, w_draw_x, w_scan_x;
  logic [YW-1:0]   w_ry, w_draw_y, w_scan_y;
  logic [c_TW-1:0] w_tries_nxt;
  logic            w_x_wrap;
  logic            w_unused_rnd;

  // r < 2*GRID_W always holds, so one conditional subtract folds it into range
  assign w_rx     = rnd[XW-1:0];
  assign w_ry     = rnd[YW-1:0];
  assign w_draw_x = ({1'b0, w_rx} >= c_GW_EXT) ? (w_rx - c_GW_LO) : w_rx;
  assign w_draw_y = ({1'b0, w_ry} >= c_GH_EXT) ? (w_ry - c_GH_LO) : w_ry;
  assign w_unused_rnd = ^rnd;

  assign w_x_wrap = (r_cand_x == c_X_LAST);
  assign w_scan_x = w_x_wrap ? '0 : r_cand_x + 1'b1;
  assign w_scan_y = !w_x_wrap ? r_cand_y :
                    (r_cand_y == c_Y_LAST) ? '0 : r_cand_y + 1'b1;

  assign w_tries_nxt = r_tries + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cand_x     <= '0;
      r_cand_y     <= '0;
      r_q_x        <= '0;
      r_q_y        <= '0;
      r_food_x     <= XW'(INIT_X);
      r_food_y     <= YW'(INIT_Y);
      r_tries      <= '0;
      r_scan_cnt   <= '0;
      r_scan_mode  <= 1'b0;
      r_q_valid    <= 1'b0;
      r_busy       <= 1'b0;
      r_food_valid <= 1'b0;
      r_grid_full  <= 1'b0;
    end else begin
      r_q_valid    <= 1'b0;
      r_food_valid <= 1'b0;
      r_grid_full  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (place_req) begin
            r_state     <= S_DRAW_X;
            r_busy      <= 1'b1;
            r_tries     <= '0;
            r_scan_mode <= 1'b0;
            r_scan_cnt  <= '0;
          end
        end
        S_DRAW_X: begin
          r_cand_x <= w_draw_x;
          r_state  <= S_DRAW_Y;
        end
        S_DRAW_Y: begin
          r_cand_y  <= w_draw_y;
          r_q_x     <= r_cand_x;
          r_q_y     <= w_draw_y;
          r_q_valid <= 1'b1;
          r_state   <= S_QUERY;
        end
        S_QUERY: r_state <= S_CHECK;
        S_CHECK: begin
          if (!occ_hit) begin
            r_food_x     <= r_cand_x;
            r_food_y     <= r_cand_y;
            r_food_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else if (!r_scan_mode) begin
            r_tries <= w_tries_nxt;
            if (w_tries_nxt == c_TRIES) begin
              r_scan_mode <= 1'b1;
              r_state     <= S_SCAN;
            end else begin
              r_state <= S_DRAW_X;
            end
          end else if (r_scan_cnt == c_CNT_LAST) begin
            r_state <= S_FAIL;
          end else begin
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_cand_x   <= w_scan_x;
          r_cand_y   <= w_scan_y;
          r_q_x      <= w_scan_x;
          r_q_y      <= w_scan_y;
          r_q_valid  <= 1'b1;
          r_scan_cnt <= r_scan_cnt + 1'b1;
          r_state    <= S_QUERY;
        end
        S_FAIL: begin
          r_grid_full <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign q_valid    = r_q_valid;
  assign q_x        = r_q_x;
  assign q_y        = r_q_y;
  assign busy       = r_busy;
  assign food_x     = r_food_x;
  assign food_y     = r_food_y;
  assign food_valid = r_food_valid;
  assign grid_full  = r_grid_full;

endmodule
`default_nettype wire

// File: tb/tb_food_placer.sv
`default_nettype none
// tb_food_placer : directed checks on a default-size food_placer and a 4x4 one
// with MAX_TRIES=2; an occupancy model answers every query one cycle later.
module tb_food_placer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       pr_a, occ_a, qv_a, busy_a, fv_a, gf_a;
  logic [7:0] rnd_a;
  logic [4:0] qx_a, qy_a, fx_a, fy_a;
  logic       pr_b, occ_b, qv_b, busy_b, fv_b, gf_b;
  logic [7:0] rnd_b;
  logic [1:0] qx_b, qy_b, fx_b, fy_b;

  food_placer dut_a (
    .clk(clk), .rst(rst), .place_req(pr_a), .rnd(rnd_a),
    .q_valid(qv_a), .q_x(qx_a), .q_y(qy_a), .occ_hit(occ_a),
    .busy(busy_a), .food_x(fx_a), .food_y(fy_a),
    .food_valid(fv_a), .grid_full(gf_a)
  );

  food_placer #(.GRID_W(4), .GRID_H(4), .MAX_TRIES(2), .INIT_X(3), .INIT_Y(2)) dut_b (
    .clk(clk), .rst(rst), .place_req(pr_b), .rnd(rnd_b),
    .q_valid(qv_b), .q_x(qx_b), .q_y(qy_b), .occ_hit(occ_b),
    .busy(busy_b), .food_x(fx_b), .food_y(fy_b),
    .food_valid(fv_b), .grid_full(gf_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // occupancy store model
  bit         oc_all, use_free;
  int         hits, qcnt;
  logic [7:0] free_x, free_y, last_qx, last_qy;

  function automatic logic occ_of(input logic [7:0] x, input logic [7:0] y);
    return oc_all || (hits > 0) || (use_free && (x != free_x || y != free_y));
  endfunction

  always @(negedge clk) begin
    if (qv_a) begin
      occ_a   = occ_of({3'b0, qx_a}, {3'b0, qy_a});
      last_qx = {3'b0, qx_a};
      last_qy = {3'b0, qy_a};
      qcnt++;
      if (hits > 0) hits--;
    end
    if (qv_b) begin
      occ_b   = occ_of({6'b0, qx_b}, {6'b0, qy_b});
      last_qx = {6'b0, qx_b};
      last_qy = {6'b0, qy_b};
      qcnt++;
      if (hits > 0) hits--;
    end
  end

  bit         cur;
  logic [7:0] rseq [16];
  logic       fv_s, gf_s, busy_s;
  assign fv_s   = cur ? fv_b   : fv_a;
  assign gf_s   = cur ? gf_b   : gf_a;
  assign busy_s = cur ? busy_b : busy_a;

  task automatic set_in(input logic pr, input logic [7:0] r);
    if (cur) begin pr_b = pr; rnd_b = r; end
    else     begin pr_a = pr; rnd_a = r; end
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 16; i++) rseq[i] = 8'hFF;
  endtask

  // rseq[m] is the rnd value sampled at edge k+m+1; lat is m where a strobe shows after edge k+m
  task automatic run_req(input bit sel, input int extra_m, input int budget,
                         output int lat, output logic fv_seen, output logic gf_seen);
    cur = sel; lat = -1; fv_seen = 1'b0; gf_seen = 1'b0; qcnt = 0;
    @(negedge clk);
    set_in(1'b1, 8'h00);
    for (int m = 0; m <= budget; m++) begin
      @(negedge clk);
      set_in(m == extra_m, (m < 16) ? rseq[m] : 8'hFF);
      if (fv_s || gf_s) begin
        lat = m; fv_seen = fv_s; gf_seen = gf_s;
        chk("busy_drops_with_strobe", busy_s, 0);
        break;
      end
    end
    set_in(1'b0, 8'h00);
  endtask

  int   lat;
  logic fv, gf, seen;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; pr_a = 0; pr_b = 0; rnd_a = 0; rnd_b = 0; occ_a = 0; occ_b = 0;
    cur = 0; oc_all = 0; use_free = 0; hits = 0; qcnt = 0;
    free_x = 0; free_y = 0; last_qx = 0; last_qy = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | qv_a | fv_a | gf_a | busy_a;
    end
    chk("rst_food_x", fx_a, 20);
    chk("rst_food_y", fy_a, 12);
    chk("rst_idle_quiet", seen, 0);
    chk("rst_q_xy", {qx_a, qy_a}, 0);
    chk("rst_b_food", {fx_b, fy_b}, {2'd3, 2'd2});

    // best case, y folded 27-24
    clear_seq(); rseq[0] = 8'h07; rseq[1] = 8'h1B;
    run_req(0, -1, 20, lat, fv, gf);
    chk("best_latency", lat, 4);
    chk("best_fv", {fv, gf}, 2'b10);
    chk("best_food", {fx_a, fy_a}, {5'd7, 5'd3});
    chk("best_query_xy", {last_qx, last_qy}, {8'd7, 8'd3});
    chk("best_queries", qcnt, 1);

    // one rejected draw, then a free one
    clear_seq(); rseq[0] = 8'h07; rseq[1] = 8'h1B; rseq[4] = 8'h02; rseq[5] = 8'h05;
    hits = 1;
    run_req(0, -1, 30, lat, fv, gf);
    chk("retry_latency", lat, 8);
    chk("retry_food", {fx_a, fy_a}, {5'd2, 5'd5});
    chk("retry_queries", qcnt, 2);

    // request while busy is dropped; y folded 29-24
    clear_seq(); rseq[0] = 8'h29; rseq[1] = 8'h3D;
    run_req(0, 1, 20, lat, fv, gf);
    chk("busyreq_latency", lat, 4);
    chk("busyreq_food", {fx_a, fy_a}, {5'd9, 5'd5});
    chk("busyreq_queries", qcnt, 1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | busy_a | fv_a;
    end
    chk("busyreq_not_queued", seen, 0);

    // 4x4: randoms (2,1),(3,3) taken, scan wraps to (0,0) then (1,0)
    clear_seq(); rseq[0] = 8'hFE; rseq[1] = 8'h01; rseq[4] = 8'h07; rseq[5] = 8'hAB;
    use_free = 1; free_x = 8'd1; free_y = 8'd0;
    run_req(1, -1, 40, lat, fv, gf);
    chk("scan_latency", lat, 14);
    chk("scan_fv", {fv, gf}, 2'b10);
    chk("scan_food", {fx_b, fy_b}, {2'd1, 2'd0});
    chk("scan_queries", qcnt, 4);

    // full grid: 2 random queries, 15 scan steps, then grid_full
    clear_seq(); rseq[0] = 8'h02; rseq[1] = 8'h03; rseq[4] = 8'h01; rseq[5] = 8'h01;
    use_free = 0; oc_all = 1;
    run_req(1, -1, 80, lat, fv, gf);
    chk("full_latency", lat, 54);
    chk("full_strobes", {fv, gf}, 2'b01);
    chk("full_queries", qcnt, 17);
    chk("full_last_query", {last_qx, last_qy}, {8'd0, 8'd1});
    chk("full_food_kept", {fx_b, fy_b}, {2'd1, 2'd0});
    @(negedge clk);
    chk("full_one_pulse", gf_b, 0);
    oc_all = 0;

    // reset during QUERY aborts with no pulse
    cur = 0;
    @(negedge clk); pr_a = 1'b1;
    @(negedge clk); pr_a = 1'b0; rnd_a = 8'h11;
    @(negedge clk); rnd_a = 8'h12;
    @(negedge clk);
    chk("mid_qvalid", qv_a, 1);
    chk("mid_query_xy", {qx_a, qy_a}, {5'd17, 5'd18});
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | fv_a | gf_a | busy_a | qv_a;
    end
    chk("mid_rst_quiet", seen, 0);
    chk("mid_rst_food", {fx_a, fy_a}, {5'd20, 5'd12});
    chk("mid_rst_q_xy", {qx_a, qy_a}, 0);
    chk("mid_rst_b_food", {fx_b, fy_b}, {2'd3, 2'd2});

    // reset beats a simultaneous request
    @(negedge clk); pr_a = 1'b1; rst = 1'b1;
    @(negedge clk); pr_a = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_beats_req", busy_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
